// File: rtl/bus_mem_responder_pkg.sv
// Shared types for the bus memory responder: word type, FSM encoding, wait-counter width
// and the sequential-access rule.
package bus_mem_responder_pkg;

  typedef logic [31:0] word_t;

  localparam int WAIT_W = 4;

  typedef logic [1:0] resp_state_t;
  localparam resp_state_t S_IDLE = 2'd0;
  localparam resp_state_t S_WAIT = 2'd1;
  localparam resp_state_t S_DONE = 2'd2;

  // An access is sequential when it follows the previous one by exactly one word (32-bit wrap).
  function automatic logic is_seq(input logic last_valid, input word_t last_addr, input word_t addr);
    return last_valid && (addr == (last_addr + 32'd4));
  endfunction

endpackage

// File: rtl/bus_mem_responder_if.sv
// CPU-to-memory bus: the master drives a registered address/store request, the slave returns
// registered read data.
interface bus_mem_responder_if;
  import bus_mem_responder_pkg::*;

  word_t addr;
  word_t wdata;
  logic  write_en;
  word_t rdata;

  modport master (output addr, output wdata, output write_en, input rdata);
  modport slave  (input addr, input wdata, input write_en, output rdata);

endinterface

// File: rtl/bus_mem_responder_sram_array.sv
// Word-wide storage with one synchronous write port and one synchronous write-first read port.
module bus_mem_responder_sram_array
  import bus_mem_responder_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  parameter int    AW        = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  word_t         wdata,
  input  logic [AW-1:0] raddr,
  output word_t         rdata
);

  word_t r_mem [DEPTH];

  // A read of the word being written returns the new data.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    if (we && (waddr == raddr)) begin
      rdata <= wdata;
    end else begin
      rdata <= r_mem[raddr];
    end
  end

endmodule

// File: rtl/bus_mem_responder.sv
// Slave end of the CPU bus: word memory with GBA-style wait states. Holds the access FSM,
// wait counter, sequential detector and range check around a synchronous SRAM.
module bus_mem_responder
  import bus_mem_responder_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter int    WAIT_N    = 3,
  parameter int    WAIT_S    = 1,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_mem_responder_if.slave    bus,
  output logic                  busy,
  output logic                  access_err
);

  localparam int                AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0]       DEPTH_W = 30'(DEPTH);
  localparam logic [WAIT_W-1:0] N_NSEQ = WAIT_W'(WAIT_N);
  localparam logic [WAIT_W-1:0] N_SEQ  = WAIT_W'(WAIT_S);

  resp_state_t       r_state;
  logic [WAIT_W-1:0] r_cnt;
  word_t             r_last_addr;
  logic              r_last_valid;
  logic [29:0]       r_widx;
  word_t             r_wdata;
  logic              r_we;
  logic              r_busy;
  logic              r_err;
  logic              r_zero;
  logic [AW-1:0]     r_disp_idx;

  logic              w_new;
  logic              w_seq;
  logic [WAIT_W-1:0] w_n;
  logic              w_complete;
  logic [29:0]       w_cmp_widx;
  word_t             w_cmp_wdata;
  logic              w_cmp_we;
  logic              w_in_range;
  logic [AW-1:0]     w_idx;
  logic              w_sram_we;
  logic [AW-1:0]     w_sram_raddr;
  word_t             w_sram_rdata;

  // In WAIT, last_addr is the in-flight address, so one test covers both start and abort.
  assign w_new = bus.write_en || (bus.addr != r_last_addr);
  assign w_seq = (r_state != S_WAIT) && is_seq(r_last_valid, r_last_addr, bus.addr);
  assign w_n   = w_seq ? N_SEQ : N_NSEQ;

  // Select which access (incoming zero-wait or latched) completes on this edge.
  always_comb begin
    w_complete  = 1'b0;
    w_cmp_widx  = r_widx;
    w_cmp_wdata = r_wdata;
    w_cmp_we    = r_we;
    if (w_new) begin
      if (w_n == {WAIT_W{1'b0}}) begin
        w_complete  = 1'b1;
        w_cmp_widx  = bus.addr[31:2];
        w_cmp_wdata = bus.wdata;
        w_cmp_we    = bus.write_en;
      end else begin
        w_complete  = 1'b0;
      end
    end else if ((r_state == S_WAIT) && (r_cnt == {WAIT_W{1'b0}})) begin
      w_complete = 1'b1;
    end else begin
      w_complete = 1'b0;
    end
  end

  assign w_in_range = (w_cmp_widx < DEPTH_W);
  assign w_idx      = w_cmp_widx[AW-1:0];
  assign w_sram_we  = !reset && w_complete && w_cmp_we && w_in_range;

  // Read address only moves on an in-range completion, so the SRAM output holds in WAIT/DONE.
  assign w_sram_raddr = (w_complete && w_in_range) ? w_idx : r_disp_idx;

  bus_mem_responder_sram_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE),
    .AW        (AW)
  ) u_sram (
    .clk   (clk),
    .we    (w_sram_we),
    .waddr (w_idx),
    .wdata (w_cmp_wdata),
    .raddr (w_sram_raddr),
    .rdata (w_sram_rdata)
  );

  // Access FSM, wait counter and completion bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= {WAIT_W{1'b0}};
      r_last_addr  <= 32'h0;
      r_last_valid <= 1'b0;
      r_widx       <= 30'h0;
      r_wdata      <= 32'h0;
      r_we         <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_zero       <= 1'b1;
      r_disp_idx   <= {AW{1'b0}};
    end else begin
      if (w_new) begin
        r_last_addr  <= bus.addr;
        r_last_valid <= 1'b1;
        r_widx       <= bus.addr[31:2];
        r_wdata      <= bus.wdata;
        r_we         <= bus.write_en;
        if (w_n == {WAIT_W{1'b0}}) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_cnt   <= {WAIT_W{1'b0}};
        end else begin
          r_state <= S_WAIT;
          r_busy  <= 1'b1;
          r_cnt   <= w_n - {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end else if (r_state == S_WAIT) begin
        if (r_cnt == {WAIT_W{1'b0}}) begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
        end else begin
          r_cnt <= r_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      if (w_complete) begin
        r_err <= !w_in_range;
        if (w_in_range) begin
          r_zero     <= 1'b0;
          r_disp_idx <= w_idx;
        end else begin
          r_zero <= 1'b1;
        end
      end else begin
        r_err <= 1'b0;
      end
    end
  end

  assign bus.rdata  = r_zero ? 32'h0 : w_sram_rdata;
  assign busy       = r_busy;
  assign access_err = r_err;

endmodule
